// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter-side signal bundle for uart_tx_arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface uart_tx_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          tx_valid;
   logic [DATA_WIDTH-1:0]         tx_data;
   logic                          busy;
   logic [ID_W-1:0]               grant_id;

   modport master (
      output req_valid,
      output req_data,
      input  req_ready,
      input  tx_valid,
      input  tx_data,
      input  busy,
      input  grant_id
   );

   modport slave (
      input  req_valid,
      input  req_data,
      output req_ready,
      output tx_valid,
      output tx_data,
      output busy,
      output grant_id
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters, timing each frame itself.
// Define UART_ARB_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module uart_tx_arbiter #(
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_REQ      = 4,
   parameter int CLKS_PER_BIT = 43,
   parameter int FRAME_BITS   = 10
) (
   input  logic                i_t_clk,
   input  logic                i_t_rst,
   uart_tx_arbiter_if.slave    io_arb
);
   localparam int ID_W       = $clog2(NUM_REQ);
   localparam int ID_W1      = ID_W + 1;
   localparam int FRAME_CLKS = FRAME_BITS * CLKS_PER_BIT;
   localparam int CNT_W      = $clog2(FRAME_CLKS);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CLKS - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_tx_valid;
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic                  r_busy;
   logic [ID_W-1:0]       r_grant_id;

   logic [DATA_WIDTH-1:0] w_byte [NUM_REQ];
   logic [ID_W-1:0]       w_cand [NUM_REQ];
   logic                  w_found;
   logic [ID_W-1:0]       w_winner;
   logic                  w_transfer;

`ifdef UART_ARB_RR_EN
   logic [ID_W-1:0]       r_ptr;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign w_byte[gi] = io_arb.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
`ifdef UART_ARB_RR_EN
         // Candidate gi is the requester gi places after the pointer, wrapped.
         logic [ID_W1-1:0] w_sum;
         assign w_sum = {1'b0, r_ptr} + ID_W1'(gi);
         assign w_cand[gi] = (w_sum >= ID_W1'(NUM_REQ)) ? ID_W'(w_sum - ID_W1'(NUM_REQ))
                                                          : w_sum[ID_W-1:0];
`else
         assign w_cand[gi] = ID_W'(gi);
`endif
         assign io_arb.req_ready[gi] = w_transfer && (w_winner == ID_W'(gi));
      end
   endgenerate

   // First valid candidate in search order wins; re-evaluated every cycle.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && io_arb.req_valid[w_cand[k]]) begin
            w_found  = 1'b1;
            w_winner = w_cand[k];
         end
      end
   end

   assign w_transfer = (r_state == ST_IDLE) && w_found;

   always_ff @(posedge i_t_clk or posedge i_t_rst) begin
      if (i_t_rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
         r_busy     <= 1'b0;
         r_grant_id <= '0;
      end else begin
         r_tx_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_transfer) begin
                  r_tx_data  <= w_byte[w_winner];
                  r_grant_id <= w_winner;
                  r_tx_valid <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               r_cnt   <= CNT_LOAD;
               r_state <= ST_HOLD;
            end
            ST_HOLD: begin
               // The transmitter has no busy flag, so the frame time is counted here.
               if (r_cnt == '0) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef UART_ARB_RR_EN
   always_ff @(posedge i_t_clk or posedge i_t_rst) begin
      if (i_t_rst) begin
         r_ptr <= '0;
      end else if (w_transfer) begin
         r_ptr <= (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
      end
   end
`endif

   assign io_arb.tx_valid = r_tx_valid;
   assign io_arb.tx_data  = r_tx_data;
   assign io_arb.busy     = r_busy;
   assign io_arb.grant_id = r_grant_id;
endmodule
